alu_mdu: RTL
============

Name: alu_mdu

Overview:
- Parametrised, registered successor to the datapath ALU, with an integrated iterative multiply/divide unit and HI/LO result registers.
- Sits in the execute stage of the MIPS core and talks to the pipeline control through a valid/ready handshake on the input and a one-cycle result pulse on the output.
- Single-cycle ops complete with one cycle of latency. MULTU/DIVU run a shift-add or restoring loop of WIDTH iterations and stall new issues while busy.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept a request this cycle
- sel  input  4  opcode (see Behaviour)
- srcA  input  WIDTH  operand A
- srcB  input  WIDTH  operand B
- flush  input  1  synchronous abort of an in-flight MULTU/DIVU
- out_valid  output  1  one-cycle pulse: result/zero/dbz valid
- result  output  WIDTH  registered result
- zero  output  1  registered (result == 0)
- dbz  output  1  registered divide-by-zero flag (DIVU only, else 0)
- busy  output  1  iterative op in progress

Behaviour:
- Reset (async, rst_n=0): state=IDLE, result=0, zero=1, dbz=0, out_valid=0, busy=0, hi=0, lo=0, counter=0. in_ready=1 once rst_n deasserts.
- Accept rule: a request is accepted on a rising edge with in_valid && in_ready. in_ready = (state==IDLE).
- Opcodes:
  - 0 AND; 1 OR; 2 ADD (mod 2^WIDTH, carry dropped); 3 XOR.
  - 4 SUB (mod 2^WIDTH); 5 MUL (low WIDTH bits of the product, single-cycle, hi/lo untouched).
  - 6 SLT (signed compare, result 1/0); 7 NOR; 8 SLTU (unsigned compare, result 1/0).
  - 9 MULTU and 10 DIVU are iterative.
  - 11 MFHI (result=hi); 12 MFLO (result=lo).
  - 13-15 undefined: result=0, zero=1, out_valid still pulses.
- Single-cycle ops: result, zero and dbz=0 are registered at the accept edge; out_valid=1 for exactly the next cycle. Back-to-back issue allowed, throughput one op per cycle.
- States: IDLE, MUL, DIV, DONE.
  - IDLE -> MUL/DIV on accept of 9/10: operands latched, counter=0, busy=1.
  - MUL/DIV perform one iteration per edge. After WIDTH iterations (counter==WIDTH-1 on the last) -> DONE.
  - DONE: hi/lo updated, result=lo, zero=(lo==0), out_valid=1, busy=0 for one cycle; in_ready stays 0 in DONE; next edge -> IDLE. No accept in DONE.
  - Latency for MULTU/DIVU: accept at edge E, iterations on edges E+1..E+WIDTH, DONE entered at edge E+WIDTH and out_valid high during cycle E+WIDTH..E+WIDTH+1; in_ready returns to 1 after edge E+WIDTH+1 (IDLE).
- MULTU: unsigned 2*WIDTH product; hi=upper WIDTH bits, lo=lower WIDTH bits.
- DIVU: unsigned restoring division; lo=quotient, hi=remainder.
  - srcB==0: no iteration shortcut (same latency); lo=all ones, hi=srcA, dbz=1 in the DONE cycle.
- flush: ignored in IDLE/DONE. In MUL/DIV, the next edge returns to IDLE with busy=0, no out_valid, and hi/lo unchanged. flush and in_valid in the same IDLE cycle: the request is accepted normally.
- Async reset mid-operation: immediate return to reset values; the in-flight result is lost and hi/lo are cleared.
- out_valid is never held; the consumer must sample it in the pulse cycle (no output backpressure).

Test Plan:
1. Reset, then rst_n=1 -> result=0, zero=1, out_valid=0, in_ready=1, busy=0; MFHI -> result 0.
2. ADD 0xFFFFFFFF+0x00000001 -> next cycle result=0x00000000, zero=1, out_valid=1; back-to-back SUB 5-7 in the following cycle -> result=0xFFFFFFFE, zero=0.
3. SLT srcA=0xFFFFFFFF, srcB=1 -> result=1; SLTU with the same operands -> result=0; sel=15 -> result=0, zero=1, out_valid=1.
4. MULTU 0xFFFFFFFF*0xFFFFFFFF -> in_ready=0 for 33 cycles, out_valid exactly 32 cycles after accept cycle +1, result=lo=0x00000001; then MFHI -> 0xFFFFFFFE.
5. DIVU 100/7 -> result=lo=14, MFHI=2, dbz=0; DIVU 7/0 -> lo=0xFFFFFFFF, hi=7, dbz=1, same latency.
6. MULTU accepted, flush on 5th iteration -> no out_valid, in_ready=1 next cycle, MFLO returns the prior lo. DIVU with rst_n pulsed low mid-loop -> all outputs at reset values immediately.

Source files
------------

// File: rtl/alu_mdu.sv
// alu_mdu: registered execute-stage ALU with an iterative unsigned
// multiply/divide unit and HI/LO result registers.
//
// Ports:
//   clk, rst_n          rising-edge clock, async active-low reset
//   in_valid/in_ready   request handshake (accepted when both high)
//   sel                 opcode, srcA/srcB operands
//   flush               abort an in-flight MULTU/DIVU
//   out_valid           one-cycle pulse qualifying result/zero/dbz
//   result, zero, dbz   registered result, result==0, divide-by-zero
//   busy                iterative operation in progress
//
// state | meaning
// IDLE  | ready; single-cycle ops complete here, MULTU/DIVU start here
// MUL   | shift-add multiply, one iteration per clock
// DIV   | restoring divide, one iteration per clock
// DONE  | hi/lo written, result pulse, one cycle then back to IDLE

module alu_mdu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       sel,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   input  logic             flush,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             dbz,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
   logic [WIDTH-1:0] hi, lo;
   logic [CNT_W-1:0] cnt;
   logic             dbz_pend;
   logic             accept, last_iter;
   logic [WIDTH-1:0] alu_res, mul_short;

   logic [WIDTH:0]   mul_sum, div_shift, div_diff;
   logic             div_ge;
   logic [WIDTH-1:0] it_hi, it_lo;

   assign in_ready  = (state == S_IDLE);
   assign busy      = (state == S_MUL) || (state == S_DIV);
   assign accept    = in_valid && in_ready;
   assign last_iter = (cnt == CNT_W'(WIDTH - 1));
   assign mul_short = srcA * srcB;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept && sel == 4'd9)  state_nxt = S_MUL;
            if (accept && sel == 4'd10) state_nxt = S_DIV;
         end
         S_MUL, S_DIV: begin
            if (flush)          state_nxt = S_IDLE;
            else if (last_iter) state_nxt = S_DONE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // {acc_hi, acc_lo} is the shared 2*WIDTH working register. For MULTU
   // acc_lo holds the multiplier and shifts right; for DIVU acc_lo holds the
   // dividend and shifts left while quotient bits enter at the bottom.
   // A zero divisor naturally yields all-ones quotient and remainder=srcA.
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
      div_shift = {acc_hi, acc_lo[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd};
      div_ge    = (div_shift >= {1'b0, opnd});
      if (state == S_MUL) begin
         it_hi = mul_sum[WIDTH:1];
         it_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
      end else begin
         it_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
         it_lo = {acc_lo[WIDTH-2:0], div_ge};
      end
   end

   always_comb begin
      alu_res = '0;
      case (sel)
         4'd0:  alu_res = srcA & srcB;
         4'd1:  alu_res = srcA | srcB;
         4'd2:  alu_res = srcA + srcB;
         4'd3:  alu_res = srcA ^ srcB;
         4'd4:  alu_res = srcA - srcB;
         4'd5:  alu_res = mul_short;
         4'd6:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
         4'd7:  alu_res = ~(srcA | srcB);
         4'd8:  alu_res = {{(WIDTH-1){1'b0}}, (srcA < srcB)};
         4'd11: alu_res = hi;
         4'd12: alu_res = lo;
         default: alu_res = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result    <= '0;
         zero      <= 1'b1;
         dbz       <= 1'b0;
         out_valid <= 1'b0;
         hi        <= '0;
         lo        <= '0;
         acc_hi    <= '0;
         acc_lo    <= '0;
         opnd      <= '0;
         cnt       <= '0;
         dbz_pend  <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (sel == 4'd9 || sel == 4'd10) begin
                     acc_hi   <= '0;
                     acc_lo   <= (sel == 4'd9) ? srcB : srcA;
                     opnd     <= (sel == 4'd9) ? srcA : srcB;
                     cnt      <= '0;
                     dbz_pend <= (sel == 4'd10) && (srcB == '0);
                  end else begin
                     result    <= alu_res;
                     zero      <= (alu_res == '0);
                     dbz       <= 1'b0;
                     out_valid <= 1'b1;
                  end
               end
            end
            S_MUL, S_DIV: begin
               if (!flush) begin
                  acc_hi <= it_hi;
                  acc_lo <= it_lo;
                  cnt    <= cnt + CNT_W'(1);
                  if (last_iter) begin
                     hi        <= it_hi;
                     lo        <= it_lo;
                     result    <= it_lo;
                     zero      <= (it_lo == '0);
                     dbz       <= dbz_pend;
                     out_valid <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
